fetch_insn_queue: RTL

Instruction queue between the fetch unit and `decode_riscv`. Each entry holds one fetched 32-bit RISC-V instruction with its PC and branch-prediction metadata: predicted-taken bit, PHT index and predicted target. The queue decouples fetch from decode stalls. It drains in program order into the decoder inputs (`insn`, `pc`, `insn_pred`, `pht_idx`, `insn_pred_target`). A pipeline flush on mispredict or restart empties it in one cycle.

---
 rtl/fetch_insn_queue.sv | 86 ++++++++
 1 files changed

// File: rtl/fetch_insn_queue.sv
// Fetch-to-decode instruction queue: circular buffer of 2**LG_DEPTH entries carrying
// insn, PC and branch-prediction metadata, drained in program order, flushed in one cycle.
module fetch_insn_queue #(
  parameter int LG_DEPTH  = 3,
  parameter int M_WIDTH   = 32,
  parameter int LG_PHT_SZ = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [31:0]          push_insn,
  input  logic [M_WIDTH-1:0]   push_pc,
  input  logic                 push_pred,
  input  logic [LG_PHT_SZ-1:0] push_pht_idx,
  input  logic [M_WIDTH-1:0]   push_pred_target,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [31:0]          pop_insn,
  output logic [M_WIDTH-1:0]   pop_pc,
  output logic                 pop_pred,
  output logic [LG_PHT_SZ-1:0] pop_pht_idx,
  output logic [M_WIDTH-1:0]   pop_pred_target,
  output logic [LG_DEPTH:0]    occupancy,
  output logic                 almost_full
);
  localparam int D = 2**LG_DEPTH;
  localparam logic [LG_DEPTH:0] PTR_ONE = (LG_DEPTH+1)'(1);
  localparam logic [LG_DEPTH:0] AF_LVL  = (LG_DEPTH+1)'(D-2);

  typedef struct packed {
    logic [31:0]          insn;
    logic [M_WIDTH-1:0]   pc;
    logic                 pred;
    logic [LG_PHT_SZ-1:0] pht_idx;
    logic [M_WIDTH-1:0]   pred_target;
  } entry_t;

  entry_t            mem [D];
  entry_t            head;
  logic [LG_DEPTH:0] rd_ptr, wr_ptr;
  logic              empty, full, push_fire, pop_fire;

  // Extra pointer MSB tells a full buffer from an empty one.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[LG_DEPTH-1:0] == wr_ptr[LG_DEPTH-1:0]) &&
                 (rd_ptr[LG_DEPTH] != wr_ptr[LG_DEPTH]);

  // Ready is independent of pop_ready so decode never combinationally gates fetch.
  assign push_ready = !full && !flush;
  assign pop_valid  = !empty && !flush;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  assign occupancy   = wr_ptr - rd_ptr;
  assign almost_full = (occupancy >= AF_LVL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_fire)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is never cleared; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (push_fire)
      mem[wr_ptr[LG_DEPTH-1:0]] <= '{insn: push_insn, pc: push_pc, pred: push_pred,
                                     pht_idx: push_pht_idx, pred_target: push_pred_target};
  end

  // Zeroed payload when not valid: decode treats insn==0 as no uop.
  assign head            = mem[rd_ptr[LG_DEPTH-1:0]];
  assign pop_insn        = pop_valid ? head.insn        : '0;
  assign pop_pc          = pop_valid ? head.pc          : '0;
  assign pop_pred        = pop_valid ? head.pred        : 1'b0;
  assign pop_pht_idx     = pop_valid ? head.pht_idx     : '0;
  assign pop_pred_target = pop_valid ? head.pred_target : '0;
endmodule
